// File: rtl/route_requester_if.sv
// Handshake bundle between one switch input port's route requester and its
// neighbours: the input buffer, the switch controller and the crossbar.
interface route_requester_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int REQUEST_WIDTH = 2
);
    // Input buffer side
    logic [DATA_WIDTH-1:0]    in_data;
    logic                     in_valid;
    logic                     in_ready;

    // Switch controller side
    logic                     routeReserveRequestValid;
    logic [REQUEST_WIDTH-1:0] routeReserveRequest;
    logic                     routeReserveStatus;
    logic                     routeRelieve;

    // Crossbar side
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     out_valid;
    logic                     out_ready;

    // The requester itself drives the master view
    modport master (
        input  in_data, in_valid, routeReserveStatus, out_ready,
        output in_ready, routeReserveRequestValid, routeReserveRequest,
               routeRelieve, out_data, out_valid
    );

    // Buffer, switch controller and crossbar together form the slave view
    modport slave (
        output in_data, in_valid, routeReserveStatus, out_ready,
        input  in_ready, routeReserveRequestValid, routeReserveRequest,
               routeRelieve, out_data, out_valid
    );
endinterface

// File: rtl/route_requester.sv
// Route requester for one switch input port: decodes the head flit's
// destination with XY routing, reserves an output port through the switch
// controller, streams the packet to the crossbar and relieves the route
// once the tail has gone through.
module route_requester #(
    parameter int N             = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int REQUEST_WIDTH = 2,
    parameter int X_ID          = 0,
    parameter int Y_ID          = 0,
    parameter int PORT_EAST     = 0,
    parameter int PORT_WEST     = 1,
    parameter int PORT_NORTH    = 2,
    parameter int PORT_SOUTH    = 3,
    parameter int PORT_LOCAL    = 0
) (
    input  logic                clk,
    input  logic                rst,
    route_requester_if.master   bus,
    output logic                protocol_error,
    output logic [15:0]         pkt_count
);

    localparam int COORD_W = $clog2(N);

    localparam logic [COORD_W-1:0] X_COORD = COORD_W'(X_ID);
    localparam logic [COORD_W-1:0] Y_COORD = COORD_W'(Y_ID);

    localparam logic [REQUEST_WIDTH-1:0] CODE_EAST  = REQUEST_WIDTH'(PORT_EAST);
    localparam logic [REQUEST_WIDTH-1:0] CODE_WEST  = REQUEST_WIDTH'(PORT_WEST);
    localparam logic [REQUEST_WIDTH-1:0] CODE_NORTH = REQUEST_WIDTH'(PORT_NORTH);
    localparam logic [REQUEST_WIDTH-1:0] CODE_SOUTH = REQUEST_WIDTH'(PORT_SOUTH);
    localparam logic [REQUEST_WIDTH-1:0] CODE_LOCAL = REQUEST_WIDTH'(PORT_LOCAL);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WAIT_GRANT = 2'd1;
    localparam logic [1:0] S_FORWARD    = 2'd2;
    localparam logic [1:0] S_RELIEVE    = 2'd3;

    logic [1:0]               r_state;
    logic                     r_reqValid;
    logic [REQUEST_WIDTH-1:0] r_request;
    logic                     r_relieve;
    logic                     r_protocolError;
    logic [15:0]              r_pktCount;
    logic                     r_firstFlit;

    logic [1:0]               w_flitType;
    logic                     w_isHeadType;
    logic                     w_isTailType;
    logic [COORD_W-1:0]       w_destX;
    logic [COORD_W-1:0]       w_destY;
    logic [REQUEST_WIDTH-1:0] w_route;
    logic                     w_inReady;
    logic                     w_outValid;
    logic [DATA_WIDTH-1:0]    w_outData;
    logic                     w_handshake;

    // Type field: bit 0 marks a packet start (head/single), bit 1 a packet end (tail/single)
    assign w_flitType   = bus.in_data[DATA_WIDTH-1:DATA_WIDTH-2];
    assign w_isHeadType = w_flitType[0];
    assign w_isTailType = w_flitType[1];
    assign w_destX      = bus.in_data[COORD_W-1:0];
    assign w_destY      = bus.in_data[2*COORD_W-1:COORD_W];
    assign w_handshake  = bus.in_valid & w_inReady;

    // XY routing: resolve X first, then Y, otherwise eject locally
    always_comb begin
        w_route = CODE_LOCAL;
        if (w_destX > X_COORD) begin
            w_route = CODE_EAST;
        end else if (w_destX < X_COORD) begin
            w_route = CODE_WEST;
        end else if (w_destY > Y_COORD) begin
            w_route = CODE_NORTH;
        end else if (w_destY < Y_COORD) begin
            w_route = CODE_SOUTH;
        end
    end

    // Buffer/crossbar handshake decoded from state; ready is held low during reset
    always_comb begin
        w_inReady  = 1'b0;
        w_outValid = 1'b0;
        w_outData  = '0;
        if (rst) begin
            case (r_state)
                S_IDLE: begin
                    w_inReady = bus.in_valid & ~w_isHeadType;
                end
                S_FORWARD: begin
                    w_inReady  = bus.out_ready;
                    w_outValid = bus.in_valid;
                    w_outData  = bus.in_data;
                end
                default: begin
                    w_inReady = 1'b0;
                end
            endcase
        end
    end

    // Reservation FSM with registered request, relieve, error and packet counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_reqValid      <= 1'b0;
            r_request       <= '0;
            r_relieve       <= 1'b0;
            r_protocolError <= 1'b0;
            r_pktCount      <= 16'd0;
            r_firstFlit     <= 1'b0;
        end else begin
            r_relieve       <= 1'b0;
            r_protocolError <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && w_isHeadType) begin
                        r_request  <= w_route;
                        r_reqValid <= 1'b1;
                        r_state    <= S_WAIT_GRANT;
                    end else if (bus.in_valid) begin
                        r_protocolError <= 1'b1;
                    end
                    if (bus.routeReserveStatus) begin
                        r_protocolError <= 1'b1;
                    end
                end
                S_WAIT_GRANT: begin
                    if (bus.routeReserveStatus) begin
                        r_reqValid  <= 1'b0;
                        r_firstFlit <= 1'b1;
                        r_state     <= S_FORWARD;
                    end
                end
                S_FORWARD: begin
                    if (bus.routeReserveStatus) begin
                        r_protocolError <= 1'b1;
                    end
                    if (w_handshake) begin
                        r_firstFlit <= 1'b0;
                        if (!r_firstFlit && w_isHeadType) begin
                            r_protocolError <= 1'b1;
                        end
                        if (w_isTailType) begin
                            r_relieve <= 1'b1;
                            r_state   <= S_RELIEVE;
                        end
                    end
                end
                S_RELIEVE: begin
                    if (bus.routeReserveStatus) begin
                        r_protocolError <= 1'b1;
                    end
                    r_pktCount <= r_pktCount + 16'd1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready                 = w_inReady;
    assign bus.out_valid                = w_outValid;
    assign bus.out_data                 = w_outData;
    assign bus.routeReserveRequestValid = r_reqValid;
    assign bus.routeReserveRequest      = r_request;
    assign bus.routeRelieve             = r_relieve;
    assign protocol_error               = r_protocolError;
    assign pkt_count                    = r_pktCount;

endmodule

// File: tb/tb_route_requester.sv
// Directed bench for route_requester on a 4x4 mesh at router (1,1).
module tb_route_requester;

    logic        clk;
    logic        rst;
    logic        protocol_error;
    logic [15:0] pkt_count;

    int testCount;
    int failCount;

    route_requester_if #(.DATA_WIDTH(8), .REQUEST_WIDTH(2)) bus ();

    route_requester #(
        .N(4), .DATA_WIDTH(8), .REQUEST_WIDTH(2), .X_ID(1), .Y_ID(1),
        .PORT_EAST(0), .PORT_WEST(1), .PORT_NORTH(2), .PORT_SOUTH(3), .PORT_LOCAL(0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .protocol_error (protocol_error),
        .pkt_count      (pkt_count)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every bench-owned input, then let combinational outputs settle
    task automatic applyStimulus(input logic [7:0] data, input logic valid,
                                 input logic outReady, input logic status);
        bus.in_data            = data;
        bus.in_valid           = valid;
        bus.out_ready          = outReady;
        bus.routeReserveStatus = status;
        #1;
    endtask

    // One comparison: count it, and report a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        rst = 1'b0;
        applyStimulus(8'h05, 1'b1, 1'b1, 1'b0);
        tick();
        tick();

        // Reset state, with a body flit presented to show ready stays low
        checkOutput("rst_reqValid", 32'(bus.routeReserveRequestValid), 0);
        checkOutput("rst_request",  32'(bus.routeReserveRequest), 0);
        checkOutput("rst_relieve",  32'(bus.routeRelieve), 0);
        checkOutput("rst_perr",     32'(protocol_error), 0);
        checkOutput("rst_pkt",      32'(pkt_count), 0);
        checkOutput("rst_inReady",  32'(bus.in_ready), 0);
        checkOutput("rst_outValid", 32'(bus.out_valid), 0);
        checkOutput("rst_outData",  32'(bus.out_data), 0);

        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick();

        // Full packet 0x47 0x05 0x8A heading EAST
        applyStimulus(8'h47, 1'b1, 1'b1, 1'b0);
        checkOutput("idle_head_inReady", 32'(bus.in_ready), 0);
        tick();
        checkOutput("east_reqValid", 32'(bus.routeReserveRequestValid), 1);
        checkOutput("east_request",  32'(bus.routeReserveRequest), 0);
        checkOutput("wait_inReady",  32'(bus.in_ready), 0);
        checkOutput("wait_outValid", 32'(bus.out_valid), 0);
        tick();
        tick();
        checkOutput("wait_hold_valid", 32'(bus.routeReserveRequestValid), 1);
        applyStimulus(8'h47, 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(8'h47, 1'b1, 1'b1, 1'b0);
        checkOutput("grant_valid_drop", 32'(bus.routeReserveRequestValid), 0);
        checkOutput("grant_request",    32'(bus.routeReserveRequest), 0);
        checkOutput("grant_perr",       32'(protocol_error), 0);
        checkOutput("fwd_head_data",    32'(bus.out_data), 32'h47);
        checkOutput("fwd_head_valid",   32'(bus.out_valid), 1);
        checkOutput("fwd_head_ready",   32'(bus.in_ready), 1);
        tick();
        checkOutput("fwd_first_perr", 32'(protocol_error), 0);

        // Backpressure on the body flit for two cycles
        applyStimulus(8'h05, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checkOutput("bp_inReady", 32'(bus.in_ready), 0);
            checkOutput("bp_outData", 32'(bus.out_data), 32'h05);
            tick();
        end
        applyStimulus(8'h05, 1'b1, 1'b1, 1'b0);
        checkOutput("bp_release_ready", 32'(bus.in_ready), 1);
        checkOutput("bp_release_data",  32'(bus.out_data), 32'h05);
        tick();
        applyStimulus(8'h8A, 1'b1, 1'b1, 1'b0);
        checkOutput("fwd_tail_data",   32'(bus.out_data), 32'h8A);
        checkOutput("fwd_tail_relieve", 32'(bus.routeRelieve), 0);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("relieve_pulse",    32'(bus.routeRelieve), 1);
        checkOutput("relieve_request",  32'(bus.routeReserveRequest), 0);
        checkOutput("relieve_inReady",  32'(bus.in_ready), 0);
        checkOutput("relieve_outValid", 32'(bus.out_valid), 0);
        checkOutput("relieve_pkt",      32'(pkt_count), 0);
        tick();
        checkOutput("relieve_end",  32'(bus.routeRelieve), 0);
        checkOutput("pkt_after_1",  32'(pkt_count), 1);

        // WEST packet with a stray head flit inside it
        applyStimulus(8'h44, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("west_request",  32'(bus.routeReserveRequest), 1);
        checkOutput("west_reqValid", 32'(bus.routeReserveRequestValid), 1);
        applyStimulus(8'h44, 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(8'h44, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(8'h47, 1'b1, 1'b1, 1'b0);
        checkOutput("stray_head_data", 32'(bus.out_data), 32'h47);
        tick();
        applyStimulus(8'h8A, 1'b1, 1'b1, 1'b0);
        checkOutput("stray_head_perr", 32'(protocol_error), 1);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("west_perr_clear", 32'(protocol_error), 0);
        checkOutput("west_relieve",    32'(bus.routeRelieve), 1);
        checkOutput("west_relieve_req", 32'(bus.routeReserveRequest), 1);
        tick();
        checkOutput("pkt_after_2", 32'(pkt_count), 2);

        // Single flit routed to the local port
        applyStimulus(8'hC5, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("local_request", 32'(bus.routeReserveRequest), 0);
        applyStimulus(8'hC5, 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(8'hC5, 1'b1, 1'b1, 1'b0);
        checkOutput("single_data",  32'(bus.out_data), 32'hC5);
        checkOutput("single_valid", 32'(bus.out_valid), 1);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("single_relieve", 32'(bus.routeRelieve), 1);
        checkOutput("single_perr",    32'(protocol_error), 0);
        tick();
        checkOutput("pkt_after_3",    32'(pkt_count), 3);
        checkOutput("single_rel_end", 32'(bus.routeRelieve), 0);

        // NORTH request, then asynchronous reset in the middle of forwarding
        applyStimulus(8'h4D, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("north_request", 32'(bus.routeReserveRequest), 2);
        applyStimulus(8'h4D, 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(8'h4D, 1'b1, 1'b1, 1'b0);
        checkOutput("pre_rst_outValid", 32'(bus.out_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_outValid", 32'(bus.out_valid), 0);
        checkOutput("async_outData",  32'(bus.out_data), 0);
        checkOutput("async_inReady",  32'(bus.in_ready), 0);
        checkOutput("async_request",  32'(bus.routeReserveRequest), 0);
        checkOutput("async_pkt",      32'(pkt_count), 0);
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick();

        // Body flit in IDLE is dropped with an error pulse
        applyStimulus(8'h05, 1'b1, 1'b1, 1'b0);
        checkOutput("idle_body_ready", 32'(bus.in_ready), 1);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("idle_body_perr",  32'(protocol_error), 1);
        checkOutput("idle_body_noreq", 32'(bus.routeReserveRequestValid), 0);
        tick();
        checkOutput("idle_body_pulse_end", 32'(protocol_error), 0);

        // Status pulse in IDLE is an error and changes nothing else
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("idle_status_perr",  32'(protocol_error), 1);
        checkOutput("idle_status_noreq", 32'(bus.routeReserveRequestValid), 0);
        tick();
        checkOutput("idle_status_end", 32'(protocol_error), 0);

        // Fresh request after reset, heading SOUTH
        applyStimulus(8'h41, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("south_reqValid", 32'(bus.routeReserveRequestValid), 1);
        checkOutput("south_request",  32'(bus.routeReserveRequest), 3);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
